// File: rtl/instr_mem_resp_pkg.sv
// rtl/instr_mem_resp_pkg.sv - shared types and constants for the instruction-memory responder
package instr_mem_resp_pkg;

    localparam int XLEN = 32;

    // ADDI x0,x0,0 returned in place of store data on an error
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    // Byte distance between consecutive instructions
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    // One response buffer entry
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] instr;
        logic            err;
    } rsp_entry_t;

    // Error cause, reserved for a future detailed error output
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } err_cause_e;

endpackage

// File: rtl/instr_mem_resp_resp_fifo.sv
// rtl/instr_mem_resp_resp_fifo.sv - parameterised synchronous FIFO with occupancy count
module resp_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointer and count update; clear wins over any push or pop
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            storage[wr_ptr] <= push_data;
        end
    end

    assign pop_data = storage[rd_ptr];

endmodule

// File: rtl/instr_mem_resp.sv
// rtl/instr_mem_resp.sv - instruction store with fetch pipeline, credit flow control and response buffer
module instr_mem_resp
    import instr_mem_resp_pkg::*;
#(
    parameter int              DEPTH     = 1024,
    parameter int              RSP_DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_instr_o,
    output logic [XLEN-1:0] rsp_addr_o,
    output logic            rsp_err_o,
    input  logic            wr_en_i,
    input  logic [XLEN-1:0] wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    logic [XLEN-1:0] store [DEPTH];

    logic            accept;
    logic            req_err;
    logic [IW-1:0]   req_idx;
    logic            wr_ok;
    logic [IW-1:0]   wr_idx;

    logic            s1_valid;
    logic [XLEN-1:0] s1_addr;
    logic            s1_err;
    logic [XLEN-1:0] s1_rdata;

    logic            fifo_clear;
    logic            fifo_pop;
    rsp_entry_t      push_entry;
    rsp_entry_t      head_entry;
    logic [CW-1:0]   count;
    logic            unused_wr_low;

    // Index bits above the store size make an address out of range
    assign req_idx = req_addr_i[IW+1:2];
    assign req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[XLEN-1:IW+2] != '0);
    assign wr_idx  = wr_addr_i[IW+1:2];
    assign wr_ok   = wr_en_i && (wr_addr_i[XLEN-1:IW+2] == '0);
    assign unused_wr_low = ^wr_addr_i[1:0];

    // Credit counts the s1 slot so a response always has a buffer entry waiting
    assign req_ready_o = !flush_i && ((int'(count) + int'(s1_valid)) < RSP_DEPTH);
    assign accept      = req_valid_i && req_ready_o;

    // Store write and synchronous read; NBA ordering gives old data on a same-index collision
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            store[wr_idx] <= wr_data_i;
        end
        if (accept && !req_err) begin
            s1_rdata <= store[req_idx];
        end
    end

    // Stage s1: holds the accepted request while its read completes
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
        end
        if (accept) begin
            s1_addr <= req_addr_i;
            s1_err  <= req_err;
        end
    end

    assign push_entry.addr  = s1_addr;
    assign push_entry.instr = s1_err ? NOP_INSTR : s1_rdata;
    assign push_entry.err   = s1_err;

    assign fifo_clear = reset_i || flush_i;
    assign fifo_pop   = rsp_valid_o && rsp_ready_i;

    resp_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (RSP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk_i),
        .clear     (fifo_clear),
        .push      (s1_valid),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .count     (count)
    );

    // Head of buffer drives the response; zeros when nothing is buffered
    always_comb begin
        rsp_valid_o = 1'b0;
        rsp_instr_o = '0;
        rsp_addr_o  = '0;
        rsp_err_o   = 1'b0;
        if (count != '0) begin
            rsp_valid_o = !flush_i;
            rsp_instr_o = head_entry.instr;
            rsp_addr_o  = head_entry.addr;
            rsp_err_o   = head_entry.err;
        end
    end

endmodule

// File: tb/tb_instr_mem_resp.sv
// tb/tb_instr_mem_resp.sv - directed self-checking bench for instr_mem_resp
module tb_instr_mem_resp;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        flush_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_instr_o;
    logic [31:0] rsp_addr_o;
    logic        rsp_err_o;
    logic        wr_en_i;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0] req_q[$];
    logic [31:0] exp_instr[$];
    logic [31:0] exp_addr[$];
    logic        exp_err[$];

    instr_mem_resp #(
        .DEPTH     (1024),
        .RSP_DEPTH (2),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .flush_i     (flush_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_instr_o (rsp_instr_o),
        .rsp_addr_o  (rsp_addr_o),
        .rsp_err_o   (rsp_err_o),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 ns after the edge, outputs sampled 1 ns later
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        flush_i     = 1'b0;
        wr_en_i     = 1'b0;
        wr_addr_i   = '0;
        wr_data_i   = '0;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        wr_en_i   = 1'b1;
        wr_addr_i = addr;
        wr_data_i = data;
        step();
        wr_en_i   = 1'b0;
    endtask

    task automatic expect_rsp(input logic [31:0] instr, input logic [31:0] addr, input logic err);
        exp_instr.push_back(instr);
        exp_addr.push_back(addr);
        exp_err.push_back(err);
    endtask

    // Drive queued requests with rsp_ready_i high and score every response in order
    task automatic run_stream(input string tag, input int budget);
        int cyc = 0;
        rsp_ready_i = 1'b1;
        while ((req_q.size() > 0 || exp_instr.size() > 0) && cyc < budget) begin
            req_valid_i = (req_q.size() > 0);
            req_addr_i  = (req_q.size() > 0) ? req_q[0] : 32'h0;
            settle();
            if (rsp_valid_o) begin
                if (exp_instr.size() == 0) begin
                    check({tag, "_extra_rsp"}, rsp_addr_o, 32'hFFFF_FFFF);
                end else begin
                    check({tag, "_instr"}, rsp_instr_o, exp_instr.pop_front());
                    check({tag, "_addr"}, rsp_addr_o, exp_addr.pop_front());
                    check({tag, "_err"}, {31'b0, rsp_err_o}, {31'b0, exp_err.pop_front()});
                end
            end
            if (req_valid_i && req_ready_o) begin
                void'(req_q.pop_front());
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        req_valid_i = 1'b0;
        check({tag, "_pending"}, req_q.size() + exp_instr.size(), 0);
        req_q.delete();
        exp_instr.delete();
        exp_addr.delete();
        exp_err.delete();
        // drain window: a faulty design could still emit an extra response
        for (int i = 0; i < 3; i++) begin
            settle();
            if (rsp_valid_o) check({tag, "_extra_rsp"}, rsp_addr_o, 32'hFFFF_FFFF);
            step();
        end
    endtask

    // Hand-traced stream for RSP_DEPTH=2: credit counts s1, so a full pipe stalls requests
    logic [31:0] t1_addr  [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic        t1_rdy   [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        t1_vld   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] t1_ins   [7] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h0, 32'h33, 32'h44};

    initial begin
        int k;
        int accepted;
        idle_inputs();
        rsp_ready_i = 1'b0;
        reset_i     = 1'b1;
        step();
        step();
        reset_i = 1'b0;
        settle();

        check("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
        check("reset_req_ready", {31'b0, req_ready_o}, 32'h1);
        check("reset_rsp_instr", rsp_instr_o, 32'h0);
        check("reset_rsp_addr", rsp_addr_o, 32'h0);
        check("reset_rsp_err", {31'b0, rsp_err_o}, 32'h0);

        write_word(32'h0, 32'h11);
        write_word(32'h4, 32'h22);
        write_word(32'h8, 32'h33);
        write_word(32'hC, 32'h44);

        // Streaming fetch with consumer always ready
        rsp_ready_i = 1'b1;
        k = 0;
        for (int c = 0; c < 7; c++) begin
            req_valid_i = (k < 4);
            req_addr_i  = (k < 4) ? t1_addr[k] : 32'h0;
            settle();
            check($sformatf("stream_ready_c%0d", c), {31'b0, req_ready_o}, {31'b0, t1_rdy[c]});
            check($sformatf("stream_valid_c%0d", c), {31'b0, rsp_valid_o}, {31'b0, t1_vld[c]});
            check($sformatf("stream_instr_c%0d", c), rsp_instr_o, t1_ins[c]);
            if (req_valid_i && req_ready_o) k++;
            step();
        end
        req_valid_i = 1'b0;
        settle();
        check("stream_done_valid", {31'b0, rsp_valid_o}, 32'h0);

        // Backpressure: only two credits
        rsp_ready_i = 1'b0;
        accepted = 0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid_i = 1'b1;
            req_addr_i  = t1_addr[k];
            settle();
            if (req_ready_o) begin
                accepted++;
                k++;
            end
            step();
        end
        req_valid_i = 1'b0;
        settle();
        check("bp_accepted", accepted, 2);
        check("bp_req_ready", {31'b0, req_ready_o}, 32'h0);
        check("bp_head_valid", {31'b0, rsp_valid_o}, 32'h1);
        check("bp_head_instr", rsp_instr_o, 32'h11);
        step();
        check("bp_head_stable", rsp_instr_o, 32'h11);
        // Already-accepted 0x0/0x4 must come out first, then the rest
        expect_rsp(32'h11, 32'h0, 1'b0);
        expect_rsp(32'h22, 32'h4, 1'b0);
        req_q.push_back(32'h8);
        req_q.push_back(32'hC);
        expect_rsp(32'h33, 32'h8, 1'b0);
        expect_rsp(32'h44, 32'hC, 1'b0);
        run_stream("bp", 40);

        // Misaligned and out-of-range requests
        req_q.push_back(32'h6);
        req_q.push_back(32'h1000);
        expect_rsp(32'h0000_0013, 32'h6, 1'b1);
        expect_rsp(32'h0000_0013, 32'h1000, 1'b1);
        run_stream("err", 20);

        // Same-cycle write and read of 0x4 returns old data
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h4;
        wr_en_i     = 1'b1;
        wr_addr_i   = 32'h4;
        wr_data_i   = 32'hAA;
        settle();
        check("rw_req_ready", {31'b0, req_ready_o}, 32'h1);
        step();
        req_valid_i = 1'b0;
        wr_en_i     = 1'b0;
        step();
        check("rw_old_valid", {31'b0, rsp_valid_o}, 32'h1);
        check("rw_old_data", rsp_instr_o, 32'h22);
        step();
        req_q.push_back(32'h4);
        expect_rsp(32'hAA, 32'h4, 1'b0);
        run_stream("rw_new", 20);

        // Flush with one buffered and one in s1
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0;
        step();
        req_addr_i  = 32'h4;
        step();
        req_valid_i = 1'b1;
        req_addr_i  = 32'hC;
        rsp_ready_i = 1'b1;
        flush_i     = 1'b1;
        settle();
        check("flush_cycle_valid", {31'b0, rsp_valid_o}, 32'h0);
        check("flush_cycle_ready", {31'b0, req_ready_o}, 32'h0);
        step();
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        settle();
        check("flush_after_valid", {31'b0, rsp_valid_o}, 32'h0);
        check("flush_after_ready", {31'b0, req_ready_o}, 32'h1);
        req_q.push_back(32'h8);
        expect_rsp(32'h33, 32'h8, 1'b0);
        run_stream("flush", 20);

        // Reset while buffer is full
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0;
        step();
        req_addr_i  = 32'hC;
        step();
        req_valid_i = 1'b0;
        step();
        check("full_count_ready", {31'b0, req_ready_o}, 32'h0);
        check("full_valid", {31'b0, rsp_valid_o}, 32'h1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        settle();
        check("rst_mid_valid", {31'b0, rsp_valid_o}, 32'h0);
        check("rst_mid_instr", rsp_instr_o, 32'h0);
        check("rst_mid_addr", rsp_addr_o, 32'h0);
        check("rst_mid_err", {31'b0, rsp_err_o}, 32'h0);
        check("rst_mid_ready", {31'b0, req_ready_o}, 32'h1);
        req_q.push_back(32'h4);
        req_q.push_back(32'hC);
        expect_rsp(32'hAA, 32'h4, 1'b0);
        expect_rsp(32'h44, 32'hC, 1'b0);
        run_stream("rst_keep", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
